// File: rtl/aorb_bist_pkg.sv
// aorb_bist shared definitions: FSM state encoding, the Gray vector
// table applied to the OR gate, and the error-counter saturation limit.
package aorb_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [7:0] ERR_MAX = 8'd255;

  // Packed Gray table, entry i at bits [2i+1:2i]: 00, 01, 11, 10.
  localparam logic [7:0] GRAY_TBL = 8'b10_11_01_00;

  function automatic logic [1:0] gray(input logic [1:0] idx);
    return GRAY_TBL[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/aorb_vec_gen.sv
// aorb_vec_gen: step counter, Gray sequencer and loop counter.
// Ports: clk/rst, en_i (advance), clr_i (zero all counters),
//   ab_o {a,b} for the current vector, vec_idx_o Gray position,
//   sample_strobe_o (last cycle of a vector while enabled),
//   last_vector_o (current vector is the final one of the run).
module aorb_vec_gen
  import aorb_bist_pkg::*;
#(
  parameter int SIM_COUNT   = 10,
  parameter int STEP_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [1:0] ab_o,
  output logic [1:0] vec_idx_o,
  output logic       sample_strobe_o,
  output logic       last_vector_o
);

  localparam int STEP_W = $clog2(STEP_CYCLES);
  localparam int LOOP_W = $clog2(SIM_COUNT + 1);

  logic [STEP_W-1:0] step_q, step_d;
  logic [1:0]        vec_q, vec_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic              step_last;

  assign step_last = (step_q == STEP_W'(STEP_CYCLES - 1));

  always_comb begin
    step_d = step_q;
    vec_d  = vec_q;
    loop_d = loop_q;
    if (clr_i) begin
      step_d = '0;
      vec_d  = '0;
      loop_d = '0;
    end else if (en_i) begin
      if (step_last) begin
        step_d = '0;
        // 2-bit index wraps 3 -> 0 on its own; the wrap closes a loop.
        vec_d  = vec_q + 2'd1;
        if (vec_q == 2'd3) begin
          loop_d = loop_q + LOOP_W'(1);
        end
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
      vec_q  <= '0;
      loop_q <= '0;
    end else begin
      step_q <= step_d;
      vec_q  <= vec_d;
      loop_q <= loop_d;
    end
  end

  assign ab_o            = gray(vec_q);
  assign vec_idx_o       = vec_q;
  assign sample_strobe_o = en_i & step_last;
  // Final vector of the final loop: its sample edge ends the run.
  assign last_vector_o   = (vec_q == 2'd3) &&
                           (loop_q == LOOP_W'(SIM_COUNT - 1));

endmodule

// File: rtl/aorb_bist.sv
// aorb_bist: on-chip self-test for the 2-input OR gate. Drives Gray
// vectors on a_out/b_out, checks f_in against a|b once per vector.
// Ports: clk, rst (async, active-high), start, f_in (gate output);
//   a_out/b_out gate drive, busy, done, pass, err_count, vec_idx.
module aorb_bist
  import aorb_bist_pkg::*;
#(
  parameter int SIM_COUNT   = 10,
  parameter int STEP_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [1:0] vec_idx
);

  state_e     state_q, state_d;
  logic [7:0] err_q, err_d;
  logic       gen_en, gen_clr;
  logic [1:0] ab;
  logic       strobe, last_vec;
  logic       mismatch;

  aorb_vec_gen #(
    .SIM_COUNT  (SIM_COUNT),
    .STEP_CYCLES(STEP_CYCLES)
  ) u_vec_gen (
    .clk            (clk),
    .rst            (rst),
    .en_i           (gen_en),
    .clr_i          (gen_clr),
    .ab_o           (ab),
    .vec_idx_o      (vec_idx),
    .sample_strobe_o(strobe),
    .last_vector_o  (last_vec)
  );

  assign mismatch = f_in != (ab[1] | ab[0]);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    gen_en  = 1'b0;
    gen_clr = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          err_d   = '0;
          gen_clr = 1'b1;
        end
      end
      ST_DRIVE: begin
        gen_en = 1'b1;
        if (strobe) begin
          if (mismatch && (err_q != ERR_MAX)) begin
            err_d = err_q + 8'd1;
          end
          if (last_vec) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == ST_DRIVE);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_q == 8'd0);
  assign err_count = err_q;
  // Gate inputs are held low outside a run.
  assign a_out     = busy & ab[1];
  assign b_out     = busy & ab[0];

endmodule
